// File: rtl/alu_frame_pkg.sv
// Shared types and constants for the framed ALU command sequencer.
// Covers FSM state encoding, STATUS byte layout and counter helpers.
package alu_frame_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StGetOpc,
        StGetA,
        StGetB,
        StGetChk,
        StExec,
        StWaitAlu,
        StTxRes,
        StWaitRes,
        StTxStat,
        StWaitStat
    } state_e;

    localparam logic [7:0] DefaultSyncByte = 8'hA5;

    localparam int unsigned StatusCoutBit   = 0;
    localparam int unsigned StatusZeroBit   = 1;
    localparam int unsigned StatusChkErrBit = 2;
    localparam int unsigned StatusOpErrBit  = 3;
    localparam int unsigned StatusSeqLsb    = 4;

    function automatic logic [7:0] pack_status(input logic [3:0] seq, input logic op_err,
                                               input logic chk_err, input logic zero,
                                               input logic cout);
        logic [7:0] s;
        s                      = '0;
        s[StatusSeqLsb +: 4]   = seq;
        s[StatusOpErrBit]      = op_err;
        s[StatusChkErrBit]     = chk_err;
        s[StatusZeroBit]       = zero;
        s[StatusCoutBit]       = cout;
        return s;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/alu_frame_ctl_if.sv
// UART and ALU handshake bundle between the frame sequencer and its peers.
// The master modport is the sequencer side; slave is the UART/ALU side.
interface alu_frame_ctl_if;
    logic       rx_d_val;
    logic [7:0] rx_data;
    logic       en_rx;
    logic       tx_d_end;
    logic [7:0] tx_data;
    logic       en_tx;
    logic [7:0] alu_data_a;
    logic [7:0] alu_data_b;
    logic [2:0] alu_cs;
    logic       alu_cin;
    logic       en_alu;
    logic [7:0] alu_s;
    logic       alu_zero;
    logic       alu_cout;

    modport master (
        input  rx_d_val, rx_data, tx_d_end, alu_s, alu_zero, alu_cout,
        output en_rx, tx_data, en_tx, alu_data_a, alu_data_b, alu_cs, alu_cin, en_alu
    );

    modport slave (
        output rx_d_val, rx_data, tx_d_end, alu_s, alu_zero, alu_cout,
        input  en_rx, tx_data, en_tx, alu_data_a, alu_data_b, alu_cs, alu_cin, en_alu
    );
endinterface

// File: rtl/frame_timer.sv
// Inter-byte timeout counter: clears on load, counts while enabled, flags the last cycle.
// expire_o is level-true at TIMEOUT_CYC-1; the consumer leaves the counting state at once.
module frame_timer #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LastCnt)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LastCnt);
endmodule

// File: rtl/alu_frame_ctl.sv
// Framed command sequencer: receives SYNC,OPC,A,B,CHK over UART, fires the ALU once
// and replies RES,STATUS; handles resync, inter-byte timeout and error counting.
module alu_frame_ctl
    import alu_frame_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = DefaultSyncByte,
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned ALU_LAT     = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_frame_ctl_if.master        bus,
    output logic                   busy,
    output logic [7:0]             err_cnt
);
    localparam int unsigned LatW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [LatW-1:0] LastLat = LatW'(ALU_LAT - 1);

    state_e state_q, state_d;
    logic [7:0] opc_q, opc_d, a_q, a_d, b_q, b_d, res_q, res_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [3:0] seq_q, seq_d;
    logic [LatW-1:0] lat_q, lat_d;
    logic zero_q, zero_d, cout_q, cout_d, chk_err_q, chk_err_d, op_err_q, op_err_d;
    logic en_rx_q, en_rx_d;
    logic timer_clr, timer_en, timer_expire;
    logic chk_err_now, op_err_now;

    frame_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (timer_clr),
        .en_i    (timer_en),
        .expire_o(timer_expire)
    );

    assign chk_err_now = (bus.rx_data != (opc_q ^ a_q ^ b_q));
    assign op_err_now  = |opc_q[7:4];

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        zero_d    = zero_q;
        cout_d    = cout_q;
        chk_err_d = chk_err_q;
        op_err_d  = op_err_q;
        seq_d     = seq_q;
        err_cnt_d = err_cnt_q;
        lat_d     = lat_q;
        timer_clr = 1'b1;
        timer_en  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.rx_d_val && (bus.rx_data == SYNC_BYTE)) state_d = StGetOpc;
            end
            StGetOpc, StGetA, StGetB, StGetChk: begin
                if (bus.rx_d_val) begin
                    // A byte arriving on the expiry cycle still belongs to the frame.
                    unique case (state_q)
                        StGetOpc: begin opc_d = bus.rx_data; state_d = StGetA;   end
                        StGetA:   begin a_d   = bus.rx_data; state_d = StGetB;   end
                        StGetB:   begin b_d   = bus.rx_data; state_d = StGetChk; end
                        default: begin
                            chk_err_d = chk_err_now;
                            op_err_d  = op_err_now;
                            if (chk_err_now || op_err_now) begin
                                res_d     = 8'h00;
                                zero_d    = 1'b0;
                                cout_d    = 1'b0;
                                err_cnt_d = sat_inc8(err_cnt_q);
                                state_d   = StTxRes;
                            end else begin
                                state_d = StExec;
                            end
                        end
                    endcase
                end else begin
                    timer_clr = 1'b0;
                    timer_en  = 1'b1;
                    if (timer_expire) begin
                        err_cnt_d = sat_inc8(err_cnt_q);
                        state_d   = StIdle;
                    end
                end
            end
            StExec: begin
                lat_d   = '0;
                state_d = StWaitAlu;
            end
            StWaitAlu: begin
                if (lat_q == LastLat) begin
                    res_d   = bus.alu_s;
                    zero_d  = bus.alu_zero;
                    cout_d  = bus.alu_cout;
                    state_d = StTxRes;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end
            StTxRes:   state_d = StWaitRes;
            StWaitRes: if (bus.tx_d_end) state_d = StTxStat;
            StTxStat:  state_d = StWaitStat;
            StWaitStat: begin
                if (bus.tx_d_end) begin
                    seq_d   = seq_q + 4'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        en_rx_d = (state_d inside {StIdle, StGetOpc, StGetA, StGetB, StGetChk});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            opc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            zero_q    <= 1'b0;
            cout_q    <= 1'b0;
            chk_err_q <= 1'b0;
            op_err_q  <= 1'b0;
            seq_q     <= '0;
            err_cnt_q <= '0;
            lat_q     <= '0;
            en_rx_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            zero_q    <= zero_d;
            cout_q    <= cout_d;
            chk_err_q <= chk_err_d;
            op_err_q  <= op_err_d;
            seq_q     <= seq_d;
            err_cnt_q <= err_cnt_d;
            lat_q     <= lat_d;
            en_rx_q   <= en_rx_d;
        end
    end

    always_comb begin
        bus.tx_data = 8'h00;
        if (state_q inside {StTxRes, StWaitRes}) begin
            bus.tx_data = res_q;
        end else if (state_q inside {StTxStat, StWaitStat}) begin
            bus.tx_data = pack_status(seq_q, op_err_q, chk_err_q, zero_q, cout_q);
        end
    end

    assign bus.en_rx      = en_rx_q;
    assign bus.en_tx      = (state_q == StTxRes) || (state_q == StTxStat);
    assign bus.en_alu     = (state_q == StExec);
    assign bus.alu_data_a = a_q;
    assign bus.alu_data_b = b_q;
    assign bus.alu_cs     = opc_q[2:0];
    assign bus.alu_cin    = opc_q[3];
    assign busy           = (state_q != StIdle);
    assign err_cnt        = err_cnt_q;
endmodule

// File: tb/tb_alu_frame_ctl.sv
// Self-checking bench for alu_frame_ctl: directed frames plus random frames scored
// against a frame-level reference model of the reply bytes and error counter.
module tb_alu_frame_ctl;
    localparam int unsigned TimeoutCyc = 1000;
    localparam int unsigned AluLat     = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [7:0] err_cnt;

    alu_frame_ctl_if bus();

    alu_frame_ctl #(
        .SYNC_BYTE  (8'hA5),
        .TIMEOUT_CYC(TimeoutCyc),
        .ALU_LAT    (AluLat)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy   (busy),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int m_seq = 0;
    int m_err = 0;

    // Behavioural ALU: cs selects the operation, result one cycle after en_alu.
    function automatic logic [8:0] ref_alu(input logic [2:0] cs, input logic cin,
                                           input logic [7:0] a, input logic [7:0] b);
        case (cs)
            3'd0:    return {1'b0, a} + {1'b0, b} + {8'd0, cin};
            3'd1:    return {1'b0, a} - {1'b0, b} - {8'd0, cin};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            default: return {1'b0, ~a};
        endcase
    endfunction

    logic [8:0] alu_r;
    assign alu_r = ref_alu(bus.alu_cs, bus.alu_cin, bus.alu_data_a, bus.alu_data_b);

    always @(posedge clk) begin
        if (bus.en_alu) begin
            bus.alu_s    <= alu_r[7:0];
            bus.alu_cout <= alu_r[8];
            bus.alu_zero <= (alu_r[7:0] == 8'h00);
        end
    end

    // Monitor: transmitted bytes and ALU fire pulses with their operands.
    logic [7:0] tx_q[$];
    int         alu_pulses = 0;
    logic [7:0] seen_a, seen_b;
    logic [3:0] seen_op;

    always @(negedge clk) begin
        if (rst_n && bus.en_tx) tx_q.push_back(bus.tx_data);
        if (rst_n && bus.en_alu) begin
            alu_pulses++;
            seen_a  = bus.alu_data_a;
            seen_b  = bus.alu_data_b;
            seen_op = {bus.alu_cin, bus.alu_cs};
        end
    end

    // UART transmitter model: finishes each byte a few cycles after en_tx.
    initial begin
        bus.tx_d_end = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.en_tx) begin
                repeat (3) @(posedge clk);
                #1 bus.tx_d_end = 1'b1;
                @(posedge clk);
                #1 bus.tx_d_end = 1'b0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        #1;
        bus.rx_d_val = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_d_val = 1'b0;
    endtask

    task automatic wait_reply(input string tag, input int want);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && (tx_q.size() >= want)) begin
                done = 1'b1;
                break;
            end
        end
        check($sformatf("%s reply_done", tag), done, 1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] opc, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] chk, input int noise,
                             input int gap_b, input bit inject);
        logic       op_err, chk_err, good;
        logic [8:0] r;
        logic [7:0] exp_res, exp_stat, nb;
        int         base_tx, base_alu;
        op_err   = (opc[7:4] != 4'h0);
        chk_err  = (chk != (opc ^ a ^ b));
        good     = !op_err && !chk_err;
        r        = good ? ref_alu(opc[2:0], opc[3], a, b) : 9'd0;
        exp_res  = r[7:0];
        exp_stat = {4'(m_seq), op_err, chk_err, good && (r[7:0] == 8'h00), r[8]};
        if (!good) m_err = (m_err == 255) ? 255 : m_err + 1;
        base_tx  = tx_q.size();
        base_alu = alu_pulses;
        for (int i = 0; i < noise; i++) begin
            nb = 8'($urandom);
            if (nb == 8'hA5) nb = 8'h5A;
            send_byte(nb, $urandom_range(0, 2));
        end
        send_byte(8'hA5, $urandom_range(0, 2));
        send_byte(opc, $urandom_range(0, 2));
        send_byte(a, $urandom_range(0, 2));
        send_byte(b, gap_b);
        send_byte(chk, $urandom_range(0, 2));
        if (inject) begin
            for (int i = 0; i < 50 && tx_q.size() == base_tx; i++) @(negedge clk);
            check($sformatf("%s en_rx_busy", tag), bus.en_rx, 0);
            send_byte(8'hA5, 0);
        end
        wait_reply(tag, base_tx + 2);
        check($sformatf("%s alu_fires", tag), alu_pulses - base_alu, good ? 1 : 0);
        check($sformatf("%s tx_count", tag), tx_q.size() - base_tx, 2);
        if (tx_q.size() >= base_tx + 2) begin
            check($sformatf("%s res", tag), tx_q[base_tx], exp_res);
            check($sformatf("%s status", tag), tx_q[base_tx + 1], exp_stat);
        end
        if (good) begin
            check($sformatf("%s alu_a", tag), seen_a, a);
            check($sformatf("%s alu_b", tag), seen_b, b);
            check($sformatf("%s alu_op", tag), seen_op, opc[3:0]);
        end
        check($sformatf("%s err_cnt", tag), err_cnt, m_err);
        m_seq = (m_seq + 1) % 16;
    endtask

    initial begin
        int         base_tx;
        logic [7:0] opc, a, b, chk;
        bus.rx_d_val = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst en_rx", bus.en_rx, 0);
        check("rst en_tx", bus.en_tx, 0);
        check("rst en_alu", bus.en_alu, 0);
        check("rst busy", busy, 0);
        check("rst err_cnt", err_cnt, 0);
        check("rst tx_data", bus.tx_data, 0);
        check("rst alu_a", bus.alu_data_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release en_rx_low", bus.en_rx, 0);
        @(posedge clk);
        #1;
        check("release en_rx_high", bus.en_rx, 1);

        // Directed frames
        run_frame("good", 8'h00, 8'h12, 8'h34, 8'h26, 0, 1, 1'b0);
        run_frame("badchk", 8'h00, 8'h12, 8'h34, 8'h00, 0, 1, 1'b0);

        // Inter-byte timeout: no reply, error counted, seq untouched
        base_tx = tx_q.size();
        send_byte(8'hA5, 1);
        send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        repeat (990) @(posedge clk);
        #1;
        check("timeout busy_before", busy, 1);
        repeat (15) @(posedge clk);
        #1;
        m_err++;
        check("timeout busy_after", busy, 0);
        check("timeout no_tx", tx_q.size() - base_tx, 0);
        check("timeout err_cnt", err_cnt, m_err);

        run_frame("after_to", 8'h00, 8'h20, 8'h22, 8'h02, 0, 1, 1'b0);
        run_frame("op_err", 8'h80, 8'h01, 8'h01, 8'h80, 0, 1, 1'b0);

        send_byte(8'h00, 1);
        send_byte(8'hFF, 0);
        send_byte(8'h3C, 0);
        run_frame("resync", 8'h00, 8'hFF, 8'h01, 8'hFE, 0, 0, 1'b0);

        // Byte landing on the expiry cycle is still accepted
        run_frame("byte_wins", 8'h00, 8'h05, 8'h07, 8'h02, 0, TimeoutCyc - 1, 1'b0);
        run_frame("rx_ignored", 8'h03, 8'h0F, 8'hF0, 8'hFC, 0, 1, 1'b1);
        run_frame("after_ign", 8'h09, 8'h40, 8'h10, 8'h59, 0, 0, 1'b0);

        // Random frames
        for (int i = 0; i < 24; i++) begin
            opc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            a   = 8'($urandom);
            b   = 8'($urandom);
            chk = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (opc ^ a ^ b);
            run_frame($sformatf("rnd%0d", i), opc, a, b, chk, $urandom_range(0, 2),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            run_frame("sat", 8'h01, 8'h11, 8'h22, 8'h00, 0, 0, 1'b0);
        end
        check("sat err_cnt_ff", err_cnt, 8'hFF);

        // Reset while waiting for the RES byte to finish
        base_tx = tx_q.size();
        send_byte(8'hA5, 1);
        send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h26, 0);
        for (int i = 0; i < 50 && tx_q.size() == base_tx; i++) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst en_tx", bus.en_tx, 0);
        check("midrst busy", busy, 0);
        check("midrst alu_a", bus.alu_data_a, 0);
        check("midrst alu_b", bus.alu_data_b, 0);
        check("midrst alu_cs", bus.alu_cs, 0);
        check("midrst tx_data", bus.tx_data, 0);
        check("midrst err_cnt", err_cnt, 0);
        check("midrst en_rx", bus.en_rx, 0);
        m_seq = 0;
        m_err = 0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        run_frame("post_rst", 8'h00, 8'h12, 8'h34, 8'h26, 0, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
